// File: rtl/num_to_ascii.sv
// Binary-to-ASCII decimal formatter: double-dabble conversion, then MSD-first digits plus separator
// over a valid/ready byte stream. Define NUM2ASCII_SIGNED_EN for two's-complement input with a '-' prefix.
module num_to_ascii #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              num_valid,
  input  logic [DATA_W-1:0] num_data,
  input  logic              sep_sel,
  output logic              num_ready,
  output logic              busy,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [2:0] {IDLE, CONV, SIGN, DIG, SEP1, SEP2} state_t;

  state_t            state;
  logic [DATA_W-1:0] bin;
  logic [BW-1:0]     bcd, bcd_adj, bcd_nxt;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx, idx_dn, lead;
  logic              sep;
`ifdef NUM2ASCII_SIGNED_EN
  logic              neg;
`endif

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // Highest nonzero nibble; an all-zero value still yields position 0 so '0' is printed.
  function automatic logic [IW-1:0] msd(input logic [BW-1:0] b);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++)
      if (b[4*i +: 4] != 4'd0) r = IW'(i);
    return r;
  endfunction

  always_comb begin
    bcd_adj = add3(bcd);
    bcd_nxt = {bcd_adj[BW-2:0], bin[DATA_W-1]};
    lead    = msd(bcd_nxt);
    idx_dn  = idx - 1'b1;
  end

  assign num_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      idx      <= '0;
      sep      <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
`ifdef NUM2ASCII_SIGNED_EN
      neg      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (num_valid) begin
          state <= CONV;
          bcd   <= '0;
          cnt   <= '0;
          sep   <= sep_sel;
`ifdef NUM2ASCII_SIGNED_EN
          neg   <= num_data[DATA_W-1];
          bin   <= num_data[DATA_W-1] ? -num_data : num_data;
`else
          bin   <= num_data;
`endif
        end
        CONV: begin
          bcd <= bcd_nxt;
          bin <= bin << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DATA_W - 1)) begin
            idx      <= lead;
            tx_valid <= 1'b1;
`ifdef NUM2ASCII_SIGNED_EN
            if (neg) begin
              state   <= SIGN;
              tx_data <= 8'h2D;
            end else
`endif
            begin
              state   <= DIG;
              tx_data <= {4'h3, bcd_nxt[{lead, 2'b00} +: 4]};
            end
          end
        end
`ifdef NUM2ASCII_SIGNED_EN
        SIGN: if (tx_ready) begin
          state   <= DIG;
          tx_data <= {4'h3, bcd[{idx, 2'b00} +: 4]};
        end
`endif
        DIG: if (tx_ready) begin
          if (idx == '0) begin
            state   <= SEP1;
            tx_data <= sep ? 8'h0D : 8'h20;
          end else begin
            idx     <= idx_dn;
            tx_data <= {4'h3, bcd[{idx_dn, 2'b00} +: 4]};
          end
        end
        SEP1: if (tx_ready) begin
          if (sep) begin
            state   <= SEP2;
            tx_data <= 8'h0A;
          end else begin
            state    <= IDLE;
            tx_valid <= 1'b0;
          end
        end
        SEP2: if (tx_ready) begin
          state    <= IDLE;
          tx_valid <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_num_to_ascii.sv
// Directed bench for num_to_ascii: a string-level decimal model feeds an expected-byte queue
// that a single monitor checks against every byte transfer.
module tb_num_to_ascii;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              num_valid = 1'b0;
  logic [DATA_W-1:0] num_data = '0;
  logic              sep_sel = 1'b0;
  logic              tx_ready = 1'b1;
  logic              num_ready, busy, tx_valid;
  logic [7:0]        tx_data;

  num_to_ascii #(.DATA_W(DATA_W), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .num_valid(num_valid), .num_data(num_data), .sep_sel(sep_sel),
    .num_ready(num_ready), .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0, cyc = 0, got_n = 0;
  logic [7:0] exp_q[$];
  int got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
  endtask

  task automatic chk_s(input string nm, input string got, input string exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got \"%s\" expected \"%s\"", nm, got, exp);
  endtask

  // Decimal text the formatter must produce for one request.
  function automatic string model(input int num, input bit sep);
    string s;
`ifdef NUM2ASCII_SIGNED_EN
    if (num >= (1 << (DATA_W - 1))) s = $sformatf("-%0d", (1 << DATA_W) - num);
    else
`endif
    s = $sformatf("%0d", num);
    return {s, sep ? "\r\n" : " "};
  endfunction

  // Monitor: every transfer must match the next expected byte; stalled bytes must hold.
  initial begin
    bit stall;
    logic [7:0] held;
    stall = 1'b0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) stall = 1'b0;
      else begin
        if (stall && tx_valid) chk("hold_tx_data", tx_data, held);
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) chk("unexpected_byte", tx_data, 256);
          else chk("tx_byte", tx_data, exp_q.pop_front());
          got_n++;
          got_cyc.push_back(cyc);
        end
        stall = tx_valid && !tx_ready;
        held = tx_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int num, input bit sep);
    string s;
    int k;
    k = 0;
    while (!num_ready && k < 100) begin tick(); k++; end
    if (!num_ready) chk("wait_num_ready", num_ready, 1);
    s = model(num, sep);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    num_valid = 1'b1;
    num_data = DATA_W'(num);
    sep_sel = sep;
    tick();
    num_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin tick(); k++; end
    if (exp_q.size() != 0) begin
      chk("drain_bytes_left", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic wait_got(input int target);
    int k;
    k = 0;
    while (got_n < target && k < 100) begin tick(); k++; end
    if (got_n < target) chk("wait_transfer", got_n, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, k;
    int vecs[6] = '{10, 9, 100, 200, 99, 1};

    tick(); tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_num_ready", num_ready, 1);
    rst = 1'b0;
    tick();

    chk_s("model_0", model(0, 0), "0 ");
    chk_s("model_7", model(7, 0), "7 ");
    chk_s("model_45", model(45, 0), "45 ");
    chk_s("model_100_crlf", model(100, 1), "100\r\n");
`ifdef NUM2ASCII_SIGNED_EN
    chk_s("model_0x80", model(128, 0), "-128 ");
`else
    chk_s("model_0x80", model(128, 0), "128 ");
    chk_s("model_255_crlf", model(255, 1), "255\r\n");
`endif

    // zero prints a single '0'; block idle right after the separator transfer
    b = got_n;
    request(0, 0);
    wait_empty();
    chk("zero_bytes", got_n - b, 2);
    chk("zero_idle_busy", busy, 0);
    chk("zero_idle_ready", num_ready, 1);

    // 255 with CR LF: latency and back-to-back transfers
    b = got_n;
    request(255, 1);
    k = 1;
    while (!tx_valid && k < 50) begin tick(); k++; end
    chk("first_valid_latency", k, DATA_W + 1);
    wait_empty();
    chk("255_bytes", got_n - b, model(255, 1).len());
    for (int i = b + 1; i < got_n; i++) chk("255_no_bubble", got_cyc[i] - got_cyc[i-1], 1);

    // backpressure on the single digit of 7
    b = got_n;
    tx_ready = 1'b0;
    request(7, 0);
    k = 0;
    while (!tx_valid && k < 50) begin tick(); k++; end
    for (int i = 0; i < 5; i++) begin
      chk("stall_tx_data", tx_data, 8'h37);
      chk("stall_tx_valid", tx_valid, 1);
      tick();
    end
    chk("stall_no_transfer", got_n - b, 0);
    tx_ready = 1'b1;
    wait_empty();
    chk("stall_bytes", got_n - b, 2);

    // request while busy is ignored
    b = got_n;
    request(123, 0);
    repeat (3) tick();
    num_valid = 1'b1;
    num_data = DATA_W'(42);
    sep_sel = 1'b1;
    tick();
    num_valid = 1'b0;
    wait_empty();
    repeat (15) tick();
    chk("ignore_busy_bytes", got_n - b, 4);
    chk("ignore_busy_idle", busy, 0);

    // reset mid-stream after the first digit
    b = got_n;
    request(123, 0);
    wait_got(b + 1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_num_ready", num_ready, 1);
    rst = 1'b0;
    request(45, 0);
    wait_empty();
    chk("midrst_bytes", got_n - b, 4);

    // most negative / high-bit value
    b = got_n;
    request(128, 0);
    wait_empty();
    chk("0x80_bytes", got_n - b, model(128, 0).len());

    // assorted values, alternating separators
    foreach (vecs[i]) begin
      b = got_n;
      request(vecs[i], i[0]);
      wait_empty();
      chk("vec_bytes", got_n - b, model(vecs[i], i[0]).len());
    end

    repeat (5) tick();
    chk("leftover_expected", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/num_to_ascii.md
# num_to_ascii

Binary-to-ASCII decimal formatter for the UART transmit path of the matrix calculator. It accepts one unsigned binary number per request and converts it to decimal with a shift-add-3 (double-dabble) engine. It then streams the digits as ASCII bytes to the UART transmitter under a valid/ready handshake, followed by a selectable separator. It is the transmit-side counterpart of the receive-side ASCII-digit parser, and emits results in the same digit/separator format the parser accepts.

## Interface
- DATA_W, 8: width of the input number, in bits.
- DIGITS, 3: number of BCD digits; must satisfy 10^DIGITS > 2^DATA_W − 1.
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- num_valid  in  1  request; the number is accepted when num_valid && num_ready at a clk edge
- num_data  in  DATA_W  number to print; sampled on acceptance
- sep_sel  in  1  separator select, sampled on acceptance: 0 = space (0x20), 1 = CR LF (0x0D, 0x0A)
- num_ready  out  1  high only in IDLE
- busy  out  1  high in every state except IDLE
- tx_data  out  8  ASCII byte to the UART transmitter
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  transmitter accepts the byte; a byte transfers when tx_valid && tx_ready at a clk edge

## Operation
- States:
  - IDLE → CONV on acceptance.
  - CONV → SIGN (macro build with a negative value) or DIG.
  - SIGN → DIG.
  - DIG → SEP1 after the last digit transfers.
  - SEP1 → SEP2 if sep_sel = 1, else → IDLE.
  - SEP2 → IDLE.
- On acceptance, the block captures num_data into a shift register and sep_sel into a register, and clears the BCD register (4·DIGITS bits).
- CONV runs exactly DATA_W iterations, one per cycle. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts {bcd, bin} left by 1.
- Leading-zero suppression: emission starts at the most significant nonzero nibble. Value 0 emits a single '0'.
- Digit byte = 0x30 | nibble, emitted most significant digit first.
- Each state that emits a byte holds tx_valid high until the transfer. tx_data is stable while tx_valid && !tx_ready.
- num_valid outside IDLE is ignored; requests are not queued.

## Timing
- Reset values: tx_valid = 0, tx_data = 0x00, busy = 0, num_ready = 1; state = IDLE; internal registers cleared.
- Reset asserted in any state: on that edge, state → IDLE and any pending byte is dropped. tx_valid is 0 and num_ready is 1 in the following cycle.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- Acceptance at edge E0. Conversion iterations occur at edges E1..E_DATA_W. The first tx_valid is high in the cycle after edge E_DATA_W, i.e. DATA_W + 1 cycles after acceptance.
- With tx_ready held high, bytes transfer on consecutive edges at one byte per cycle, with no bubbles between digits and separator.
- The edge transferring the final separator byte returns the block to IDLE. num_ready is high in the next cycle, and a new request can be accepted at the following edge.
- Total occupancy with no backpressure: DATA_W + (number of bytes emitted) cycles.
- tx_ready is allowed high while tx_valid is low; it has no effect.

## Configuration
- Macro: NUM2ASCII_SIGNED_EN.
- Defined:
  - num_data is two's complement.
  - If the MSB is set, the magnitude (−num_data, treated as an unsigned DATA_W value) is converted, and SIGN emits '-' (0x2D) before the digits.
  - Most negative value prints correctly (8-bit 0x80 → "-128").
  - Latency to the first tx_valid is unchanged (DATA_W + 1); the first byte is '-'.
- Undefined:
  - num_data is unsigned; the SIGN state and negation logic are not built.
  - 0x80 prints as "128".

## Test plan
- num_data = 0, sep_sel = 0, tx_ready = 1 → bytes 0x30, 0x20; busy low and num_ready high right after the 0x20 transfer.
- num_data = 255, sep_sel = 1 → bytes 0x32, 0x35, 0x35, 0x0D, 0x0A on consecutive cycles; first tx_valid exactly 9 cycles after acceptance.
- num_data = 7, tx_ready low for 5 cycles once tx_valid rises → tx_data held at 0x37 throughout; exactly one transfer, then 0x20.
- Accept 123; pulse num_valid with num_data = 42 while busy → only 0x31, 0x32, 0x33, 0x20 emitted; 42 never appears.
- Assert rst after the 0x31 of 123 transfers → tx_valid = 0 and num_ready = 1 in the next cycle. Then request 45 with sep_sel = 0 → 0x34, 0x35, 0x20.
- num_data = 0x80: with NUM2ASCII_SIGNED_EN → 0x2D, 0x31, 0x32, 0x38, 0x20; without it → 0x31, 0x32, 0x38, 0x20.
